// File: rtl/rs_issue_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rs_issue_controller_pkg
//  Brief    : Opcodes, instruction field slices and tag constants for issue.
//  Revision : 1.0  initial release
// ============================================================================
package rs_issue_controller_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam int         TAG_NONE = 0;

  // Instruction layout: [11:9]=srcB [8:6]=dest [5:3]=srcA [2:0]=op
  function automatic logic [2:0] inst_op(input logic [11:0] i);
    return i[2:0];
  endfunction

  function automatic logic [2:0] inst_srca(input logic [11:0] i);
    return i[5:3];
  endfunction

  function automatic logic [2:0] inst_dest(input logic [11:0] i);
    return i[8:6];
  endfunction

  function automatic logic [2:0] inst_srcb(input logic [11:0] i);
    return i[11:9];
  endfunction

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_issue_controller_free_finder.sv
`default_nettype none
// ============================================================================
//  Module   : rs_free_finder
//  Brief    : Lowest-index free reservation station encoder.
//  Revision : 1.0  initial release
// ============================================================================
module rs_free_finder #(
  parameter int NUM_RS = 3,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_RS-1:0] busy,
  output logic [IDX_W-1:0]  idx,
  output logic              any_free
);

  // Scan downward so the lowest free index is the last one written.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        idx      = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs_issue_controller.sv
`default_nettype none
// ============================================================================
//  Module   : rs_issue_controller
//  Brief    : ADD/SUB issue stage: RS allocation, register status, CDB free.
//  Revision : 1.0  initial release
// ============================================================================
module rs_issue_controller
  import rs_issue_controller_pkg::*;
#(
  parameter int NUM_RS   = 3,
  parameter int NUM_REGS = 8,
  parameter int TAG_W    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_valid,
  input  logic [11:0]      inst,
  output logic             stall,
  output logic [2:0]       rs_count,
  output logic             issue_valid,
  output logic [TAG_W-1:0] issue_slot,
  output logic [2:0]       issue_op,
  output logic [2:0]       issue_dest,
  output logic [TAG_W-1:0] issue_qa,
  output logic [TAG_W-1:0] issue_qb,
  output logic             issue_fwd_a,
  output logic             issue_fwd_b,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag
);

  logic [NUM_RS-1:0] r_busy;
  logic [NUM_RS-1:0] w_busy_next;
  logic [TAG_W-1:0]  r_reg_tag [NUM_REGS];
  logic [TAG_W-1:0]  w_free_idx;
  logic              w_any_free;
  logic [2:0]        w_op, w_dest, w_srca, w_srcb;
  logic              w_is_alu, w_issue, w_cdb_hit;
  logic [TAG_W-1:0]  w_new_tag, w_tag_a, w_tag_b;
  logic              w_fwd_a, w_fwd_b;
  logic [2:0]        w_count_next;

  rs_free_finder #(
    .NUM_RS (NUM_RS),
    .IDX_W  (TAG_W)
  ) u_free_finder (
    .busy     (r_busy),
    .idx      (w_free_idx),
    .any_free (w_any_free)
  );

  assign w_op     = inst_op(inst);
  assign w_dest   = inst_dest(inst);
  assign w_srca   = inst_srca(inst);
  assign w_srcb   = inst_srcb(inst);
  assign w_is_alu = is_alu_op(w_op);

  // Registered count only: a same-cycle CDB free must not reach the PC.
  assign stall     = inst_valid && w_is_alu && (rs_count == 3'(NUM_RS));
  assign w_issue   = inst_valid && w_is_alu && !stall && w_any_free;
  assign w_new_tag = w_free_idx + TAG_W'(1);

  assign w_tag_a = r_reg_tag[w_srca];
  assign w_tag_b = r_reg_tag[w_srcb];
  assign w_fwd_a = w_cdb_hit && (w_tag_a == cdb_tag);
  assign w_fwd_b = w_cdb_hit && (w_tag_b == cdb_tag);

  // A completion only counts when it names a station that is actually busy.
  always_comb begin
    w_cdb_hit = 1'b0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (cdb_valid && (cdb_tag == TAG_W'(i + 1)) && r_busy[i]) w_cdb_hit = 1'b1;
    end
  end

  always_comb begin
    w_busy_next  = r_busy;
    w_count_next = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (w_cdb_hit && (cdb_tag == TAG_W'(i + 1))) w_busy_next[i] = 1'b0;
      if (w_issue && (w_free_idx == TAG_W'(i)))    w_busy_next[i] = 1'b1;
    end
    for (int i = 0; i < NUM_RS; i++) begin
      w_count_next = w_count_next + 3'(w_busy_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy      <= '0;
      rs_count    <= '0;
      issue_valid <= 1'b0;
      issue_slot  <= '0;
      issue_op    <= '0;
      issue_dest  <= '0;
      issue_qa    <= '0;
      issue_qb    <= '0;
      issue_fwd_a <= 1'b0;
      issue_fwd_b <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) r_reg_tag[r] <= TAG_W'(TAG_NONE);
    end else begin
      r_busy      <= w_busy_next;
      rs_count    <= w_count_next;
      issue_valid <= w_issue;
      // The issuing write wins over a CDB clear of the same register.
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_issue && (w_dest == 3'(r)))
          r_reg_tag[r] <= w_new_tag;
        else if (w_cdb_hit && (r_reg_tag[r] == cdb_tag))
          r_reg_tag[r] <= TAG_W'(TAG_NONE);
      end
      if (w_issue) begin
        issue_slot  <= w_free_idx;
        issue_op    <= w_op;
        issue_dest  <= w_dest;
        issue_qa    <= w_fwd_a ? TAG_W'(TAG_NONE) : w_tag_a;
        issue_qb    <= w_fwd_b ? TAG_W'(TAG_NONE) : w_tag_b;
        issue_fwd_a <= w_fwd_a;
        issue_fwd_b <= w_fwd_b;
      end
    end
  end

  a_cdb_legal: assert property (@(posedge clk) disable iff (reset) cdb_valid |-> w_cdb_hit);

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_issue_controller
//  Brief    : Scoreboard bench for rs_issue_controller with directed vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rs_issue_controller;

  typedef struct packed {
    logic [1:0] slot;
    logic [2:0] op;
    logic [2:0] dest;
    logic [1:0] qa;
    logic [1:0] qb;
    logic       fa;
    logic       fb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic [11:0] inst;
  logic        stall;
  logic [2:0]  rs_count;
  logic        issue_valid;
  logic [1:0]  issue_slot;
  logic [2:0]  issue_op;
  logic [2:0]  issue_dest;
  logic [1:0]  issue_qa;
  logic [1:0]  issue_qb;
  logic        issue_fwd_a;
  logic        issue_fwd_b;
  logic        cdb_valid;
  logic [1:0]  cdb_tag;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  rs_issue_controller #(.NUM_RS(3), .NUM_REGS(8), .TAG_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .stall       (stall),
    .rs_count    (rs_count),
    .issue_valid (issue_valid),
    .issue_slot  (issue_slot),
    .issue_op    (issue_op),
    .issue_dest  (issue_dest),
    .issue_qa    (issue_qa),
    .issue_qb    (issue_qb),
    .issue_fwd_a (issue_fwd_a),
    .issue_fwd_b (issue_fwd_b),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    inst       = 12'h000;
    cdb_valid  = 1'b0;
    cdb_tag    = 2'd0;
  endtask

  task automatic drive(input logic [11:0] i, input logic v, input logic cv, input logic [1:0] ct);
    inst       = i;
    inst_valid = v;
    cdb_valid  = cv;
    cdb_tag    = ct;
    #1;
  endtask

  function automatic exp_t mk(input logic [1:0] slot, input logic [2:0] op, input logic [2:0] dest,
                              input logic [1:0] qa, input logic [1:0] qb, input logic fa, input logic fb);
    exp_t e;
    e.slot = slot; e.op = op; e.dest = dest; e.qa = qa; e.qb = qb; e.fa = fa; e.fb = fb;
    return e;
  endfunction

  // Monitor: every issue pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && issue_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", 32'(issue_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_slot", 32'(issue_slot), 32'(e.slot));
        chk("issue_op", 32'(issue_op), 32'(e.op));
        chk("issue_dest", 32'(issue_dest), 32'(e.dest));
        chk("issue_qa", 32'(issue_qa), 32'(e.qa));
        chk("issue_qb", 32'(issue_qb), 32'(e.qb));
        chk("issue_fwd_a", 32'(issue_fwd_a), 32'(e.fa));
        chk("issue_fwd_b", 32'(issue_fwd_b), 32'(e.fb));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; inst_valid = 1'b0; inst = 12'h000; cdb_valid = 1'b0; cdb_tag = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_count", 32'(rs_count), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_issue_valid", 32'(issue_valid), 32'd0);

    // R2 = R0 + R1 -> slot 0
    exp_q.push_back(mk(2'd0, 3'b000, 3'd2, 2'd0, 2'd0, 1'b0, 1'b0));
    drive(12'b001_010_000_000, 1'b1, 1'b0, 2'd0); tick();
    chk("count_after_1", 32'(rs_count), 32'd1);

    // R4 = R2 - R0 -> slot 1, qa = tag 1
    exp_q.push_back(mk(2'd1, 3'b001, 3'd4, 2'd1, 2'd0, 1'b0, 1'b0));
    drive(12'b000_100_010_001, 1'b1, 1'b0, 2'd0); tick();
    chk("count_after_2", 32'(rs_count), 32'd2);

    // R6 = R0 + R0 -> slot 2
    exp_q.push_back(mk(2'd2, 3'b000, 3'd6, 2'd0, 2'd0, 1'b0, 1'b0));
    drive(12'b000_110_000_000, 1'b1, 1'b0, 2'd0); tick();
    chk("count_full", 32'(rs_count), 32'd3);

    // Fourth ADD R7 = R6 + R4 held off while full
    drive(12'b100_111_110_000, 1'b1, 1'b0, 2'd0);
    chk("stall_full", 32'(stall), 32'd1);
    tick();
    chk("count_held", 32'(rs_count), 32'd3);

    // Bubble never stalls and never issues
    drive(12'hFFF, 1'b1, 1'b0, 2'd0);
    chk("bubble_stall", 32'(stall), 32'd0);
    tick();
    chk("bubble_count", 32'(rs_count), 32'd3);

    // Same-cycle CDB free does not lift the stall
    drive(12'b100_111_110_000, 1'b1, 1'b1, 2'd2);
    chk("stall_with_cdb", 32'(stall), 32'd1);
    tick();
    chk("count_after_free2", 32'(rs_count), 32'd2);

    // Fourth ADD now issues into slot 1; R4 cleared, R6 still tag 3
    exp_q.push_back(mk(2'd1, 3'b000, 3'd7, 2'd3, 2'd0, 1'b0, 1'b0));
    drive(12'b100_111_110_000, 1'b1, 1'b0, 2'd0);
    chk("stall_lifted", 32'(stall), 32'd0);
    tick();
    chk("count_refill", 32'(rs_count), 32'd3);

    // Free tag 3, then R5 = R2 + R2 with tag 1 completing in the same cycle
    drive(12'h000, 1'b0, 1'b1, 2'd3); tick();
    chk("count_after_free3", 32'(rs_count), 32'd2);
    exp_q.push_back(mk(2'd2, 3'b000, 3'd5, 2'd0, 2'd0, 1'b1, 1'b1));
    drive(12'b010_101_010_000, 1'b1, 1'b1, 2'd1); tick();
    chk("count_issue_and_free", 32'(rs_count), 32'd2);

    // Free tag 3 (R5), then R4 = R0 + R0 -> slot 0, tag 1
    drive(12'h000, 1'b0, 1'b1, 2'd3); tick();
    chk("count_one", 32'(rs_count), 32'd1);
    exp_q.push_back(mk(2'd0, 3'b000, 3'd4, 2'd0, 2'd0, 1'b0, 1'b0));
    drive(12'b000_100_000_000, 1'b1, 1'b0, 2'd0); tick();

    // CDB tag 1 clears R4 while R4 = R4 + R1 writes it -> new tag 3 wins
    exp_q.push_back(mk(2'd2, 3'b000, 3'd4, 2'd0, 2'd0, 1'b1, 1'b0));
    drive(12'b001_100_100_000, 1'b1, 1'b1, 2'd1); tick();
    chk("count_net_same", 32'(rs_count), 32'd2);

    // R6 = R4 + R7 sees R4 = tag 3 and R7 = tag 2
    exp_q.push_back(mk(2'd0, 3'b000, 3'd6, 2'd3, 2'd2, 1'b0, 1'b0));
    drive(12'b111_110_100_000, 1'b1, 1'b0, 2'd0); tick();
    chk("count_full_again", 32'(rs_count), 32'd3);

    // Drop to two busy, then reset with tags live
    drive(12'h000, 1'b0, 1'b1, 2'd1); tick();
    chk("count_before_reset", 32'(rs_count), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_count", 32'(rs_count), 32'd0);
    chk("midreset_issue_valid", 32'(issue_valid), 32'd0);

    // R3 = R4 + R7: all tags discarded, slot 0
    exp_q.push_back(mk(2'd0, 3'b000, 3'd3, 2'd0, 2'd0, 1'b0, 1'b0));
    drive(12'b111_011_100_000, 1'b1, 1'b0, 2'd0);
    chk("midreset_stall", 32'(stall), 32'd0);
    tick();
    chk("count_post_reset", 32'(rs_count), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
